// File: rtl/rbus_vo_pkg.sv
// Shared definitions for the video-out event sequencer: event codes, FSM states,
// configuration step count and the snapshot record.
package rbus_vo_pkg;

  localparam logic [7:0] CMD_VGA_SET_BASE_ADDR = 8'h20;
  localparam logic [7:0] CMD_VGA_SET_PH_WIDTH  = 8'h21;
  localparam logic [7:0] CMD_VGA_SET_LO_WIDTH  = 8'h22;
  localparam logic [7:0] CMD_VGA_SET_LO_HEIGHT = 8'h23;
  localparam logic [7:0] CMD_VGA_SET_MODE      = 8'h24;
  localparam logic [7:0] CMD_VGA_SET_TEXT_ENA  = 8'h25;
  localparam logic [7:0] CMD_VGA_PUT_CHAR      = 8'h26;
  localparam logic [7:0] CMD_VGA_SET_H_POL     = 8'h27;
  localparam logic [7:0] CMD_VGA_SET_V_POL     = 8'h28;

  localparam int CFG_STEPS = 8;
  localparam int STEP_W    = $clog2(CFG_STEPS);

  typedef logic [STEP_W-1:0] step_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_CHAR = 2'd2
  } state_e;

  typedef struct packed {
    logic [38:0] base_addr;
    logic [11:0] ph_width;
    logic [11:0] lo_width;
    logic [11:0] lo_height;
    logic [1:0]  mode;
    logic        h_pol;
    logic        v_pol;
    logic        text_ena;
  } cfg_snap_t;

  localparam logic [7:0] CHR_OFS = CMD_VGA_PUT_CHAR - CMD_VGA_SET_BASE_ADDR;

  // Event code offset (relative to the base code) emitted at each configuration step.
  function automatic logic [7:0] cfg_step_ofs(input step_t step);
    logic [7:0] code;
    case (step)
      3'd0:    code = CMD_VGA_SET_BASE_ADDR;
      3'd1:    code = CMD_VGA_SET_PH_WIDTH;
      3'd2:    code = CMD_VGA_SET_LO_WIDTH;
      3'd3:    code = CMD_VGA_SET_LO_HEIGHT;
      3'd4:    code = CMD_VGA_SET_MODE;
      3'd5:    code = CMD_VGA_SET_H_POL;
      3'd6:    code = CMD_VGA_SET_V_POL;
      default: code = CMD_VGA_SET_TEXT_ENA;
    endcase
    return code - CMD_VGA_SET_BASE_ADDR;
  endfunction

endpackage

// File: rtl/rbus_vo_chr_fifo.sv
// Single-clock character FIFO with a show-ahead head word; push while full is
// accepted only when a pop happens in the same cycle.
module rbus_vo_chr_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/rbus_vo_evt_seq.sv
// Event master for the video-out box: replays the configuration sequence on request
// and drains queued characters as PUT_CHAR events in between.
module rbus_vo_evt_seq
  import rbus_vo_pkg::*;
#(
  parameter int         FIFO_DEPTH = 16,
  parameter bit         AUTO_START = 1'b1,
  parameter logic [7:0] CMD_BASE   = 8'h20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_start,
  input  logic [38:0] cfg_base_addr,
  input  logic [11:0] cfg_ph_width,
  input  logic [11:0] cfg_lo_width,
  input  logic [11:0] cfg_lo_height,
  input  logic [1:0]  cfg_mode,
  input  logic        cfg_h_pol,
  input  logic        cfg_v_pol,
  input  logic        cfg_text_ena,
  output logic        cfg_busy,
  input  logic        chr_stb,
  input  logic [7:0]  chr_dat,
  output logic        chr_rdy,
  output logic        eve_stb,
  output logic [7:0]  eve_cmd,
  output logic [39:0] eve_ptr,
  input  logic        eve_ack
);

  localparam step_t LAST_STEP = step_t'(CFG_STEPS - 1);

  state_e      state_q, state_d;
  step_t       step_q, step_d;
  cfg_snap_t   snap_q, snap_d;
  logic        pend_q, pend_d;
  logic        eve_stb_q, eve_stb_d;
  logic [7:0]  eve_cmd_q, eve_cmd_d;
  logic [39:0] eve_ptr_q, eve_ptr_d;
  logic [39:0] cfg_arg;
  logic        seq_start, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]  fifo_head;

  rbus_vo_chr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (chr_stb && chr_rdy),
    .din   (chr_dat),
    .pop   (fifo_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign chr_rdy  = !fifo_full;
  assign cfg_busy = pend_q || (state_q == ST_CFG);
  assign eve_stb  = eve_stb_q;
  assign eve_cmd  = eve_cmd_q;
  assign eve_ptr  = eve_ptr_q;

  always_comb begin
    case (step_q)
      3'd0:    cfg_arg = {1'b0, snap_q.base_addr};
      3'd1:    cfg_arg = {28'd0, snap_q.ph_width};
      3'd2:    cfg_arg = {28'd0, snap_q.lo_width};
      3'd3:    cfg_arg = {28'd0, snap_q.lo_height};
      3'd4:    cfg_arg = {38'd0, snap_q.mode};
      3'd5:    cfg_arg = {39'd0, snap_q.h_pol};
      3'd6:    cfg_arg = {39'd0, snap_q.v_pol};
      default: cfg_arg = {39'd0, snap_q.text_ena};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    snap_d    = snap_q;
    eve_stb_d = eve_stb_q;
    eve_cmd_d = eve_cmd_q;
    eve_ptr_d = eve_ptr_q;
    seq_start = 1'b0;
    fifo_pop  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // A pending configuration always wins over queued characters.
        if (pend_q) begin
          state_d          = ST_CFG;
          step_d           = '0;
          seq_start        = 1'b1;
          snap_d.base_addr = cfg_base_addr;
          snap_d.ph_width  = cfg_ph_width;
          snap_d.lo_width  = cfg_lo_width;
          snap_d.lo_height = cfg_lo_height;
          snap_d.mode      = cfg_mode;
          snap_d.h_pol     = cfg_h_pol;
          snap_d.v_pol     = cfg_v_pol;
          snap_d.text_ena  = cfg_text_ena;
        end else if (!fifo_empty) begin
          state_d = ST_CHAR;
        end
      end
      ST_CFG: begin
        if (!eve_stb_q) begin
          eve_stb_d = 1'b1;
          eve_cmd_d = CMD_BASE + cfg_step_ofs(step_q);
          eve_ptr_d = cfg_arg;
        end else if (eve_ack) begin
          eve_stb_d = 1'b0;
          if (step_q == LAST_STEP) state_d = ST_IDLE;
          else                     step_d  = step_q + step_t'(1);
        end
      end
      ST_CHAR: begin
        if (!eve_stb_q) begin
          eve_stb_d = 1'b1;
          eve_cmd_d = CMD_BASE + CHR_OFS;
          eve_ptr_d = {32'd0, fifo_head};
        end else if (eve_ack) begin
          eve_stb_d = 1'b0;
          fifo_pop  = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    pend_d = (pend_q && !seq_start) || cfg_start;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      step_q    <= '0;
      snap_q    <= '0;
      pend_q    <= AUTO_START;
      eve_stb_q <= 1'b0;
      eve_cmd_q <= '0;
      eve_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      snap_q    <= snap_d;
      pend_q    <= pend_d;
      eve_stb_q <= eve_stb_d;
      eve_cmd_q <= eve_cmd_d;
      eve_ptr_q <= eve_ptr_d;
    end
  end

endmodule

// File: tb/tb_rbus_vo_evt_seq.sv
// Scoreboard bench: stimulus queues expected events, a monitor drives eve_ack and
// compares every transfer against the queue.
module tb_rbus_vo_evt_seq;

  localparam logic [7:0] CB = 8'h20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cfg_start = 1'b0;
  logic [38:0] cfg_base_addr = '0;
  logic [11:0] cfg_ph_width = '0, cfg_lo_width = '0, cfg_lo_height = '0;
  logic [1:0]  cfg_mode = '0;
  logic        cfg_h_pol = 1'b0, cfg_v_pol = 1'b0, cfg_text_ena = 1'b0;
  logic        cfg_busy;
  logic        chr_stb = 1'b0;
  logic [7:0]  chr_dat = '0;
  logic        chr_rdy;
  logic        eve_stb;
  logic [7:0]  eve_cmd;
  logic [39:0] eve_ptr;
  logic        eve_ack = 1'b0;

  rbus_vo_evt_seq #(.FIFO_DEPTH(16), .AUTO_START(1'b1), .CMD_BASE(CB)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base_addr(cfg_base_addr),
    .cfg_ph_width(cfg_ph_width), .cfg_lo_width(cfg_lo_width), .cfg_lo_height(cfg_lo_height),
    .cfg_mode(cfg_mode), .cfg_h_pol(cfg_h_pol), .cfg_v_pol(cfg_v_pol),
    .cfg_text_ena(cfg_text_ena), .cfg_busy(cfg_busy), .chr_stb(chr_stb), .chr_dat(chr_dat),
    .chr_rdy(chr_rdy), .eve_stb(eve_stb), .eve_cmd(eve_cmd), .eve_ptr(eve_ptr),
    .eve_ack(eve_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [39:0] ptr;
    bit          gap;
  } exp_t;

  typedef struct {
    logic [38:0] base;
    logic [11:0] ph, lw, lh;
    logic [1:0]  mode;
    logic        hp, vp, te;
  } cfg_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_mode = 1;   // 0 hold low, 1 always, 2 after 3 cycles of stb, 3 random
  int   xfer_cnt = 0;
  int   cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    c.base = r[38:0];
    r = {$urandom(), $urandom()};
    c.ph = r[11:0]; c.lw = r[23:12]; c.lh = r[35:24]; c.mode = r[37:36];
    c.hp = r[38]; c.vp = r[39]; c.te = r[40];
    return c;
  endfunction

  task automatic drive_cfg(input cfg_t c);
    cfg_base_addr = c.base; cfg_ph_width = c.ph; cfg_lo_width = c.lw;
    cfg_lo_height = c.lh; cfg_mode = c.mode; cfg_h_pol = c.hp;
    cfg_v_pol = c.vp; cfg_text_ena = c.te;
  endtask

  // Reference: the eight configuration events in emission order.
  task automatic push_seq(input cfg_t c, input bit gap);
    logic [7:0]  ofs [8];
    logic [39:0] args [8];
    ofs = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd5};
    args[0] = {1'b0, c.base};  args[1] = {28'd0, c.ph};
    args[2] = {28'd0, c.lw};   args[3] = {28'd0, c.lh};
    args[4] = {38'd0, c.mode}; args[5] = {39'd0, c.hp};
    args[6] = {39'd0, c.vp};   args[7] = {39'd0, c.te};
    for (int k = 0; k < 8; k++)
      exp_q.push_back('{cmd: CB + ofs[k], ptr: args[k], gap: gap && (k != 0)});
  endtask

  task automatic push_chr_exp(input logic [7:0] d);
    exp_q.push_back('{cmd: CB + 8'd6, ptr: {32'd0, d}, gap: 1'b0});
  endtask

  task automatic chr_write(input logic [7:0] d);
    chr_stb = 1'b1;
    chr_dat = d;
    step();
    chr_stb = 1'b0;
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int stable = 0;
    int n = 0;
    while (stable < 4 && n < 3000) begin
      step();
      n++;
      if (exp_q.size() == 0 && !cfg_busy && !eve_stb) stable++;
      else stable = 0;
    end
    if (stable < 4) begin
      checks++; errors++;
      $display("FAIL %s timeout pending=%0d required=0", nm, exp_q.size());
    end
  endtask

  task automatic wait_for_cmd(input logic [7:0] c);
    int n = 0;
    while (!(eve_stb && eve_cmd == c) && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL wait_cmd timeout actual=%0h required=%0h", eve_cmd, c);
    end
  endtask

  // Monitor: decides eve_ack for the coming edge and scores each transfer.
  initial begin
    exp_t e;
    bit   prev_pend = 0, prev_xfer = 0, a, xfer;
    logic [7:0]  prev_cmd = '0;
    logic [39:0] prev_ptr = '0;
    int   wait_cnt = 0;
    int   last_xfer_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        eve_ack = 1'b0; prev_pend = 0; prev_xfer = 0; wait_cnt = 0;
        continue;
      end
      if (prev_pend) begin
        chk("hold_stb", 64'(eve_stb), 64'(1));
        chk("hold_cmd", 64'(eve_cmd), 64'(prev_cmd));
        chk("hold_ptr", 64'(eve_ptr), 64'(prev_ptr));
      end
      if (prev_xfer) chk("gap_stb_low", 64'(eve_stb), 64'(0));
      if (eve_stb) wait_cnt++;
      else         wait_cnt = 0;
      case (ack_mode)
        0:       a = 1'b0;
        1:       a = 1'b1;
        2:       a = (wait_cnt >= 3);
        default: a = 1'($urandom_range(0, 1));
      endcase
      eve_ack = a;
      xfer = eve_stb && a;
      if (xfer) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event actual=%0h/%0h required=none", eve_cmd, eve_ptr);
        end else begin
          e = exp_q.pop_front();
          chk("evt_cmd", 64'(eve_cmd), 64'(e.cmd));
          chk("evt_ptr", 64'(eve_ptr), 64'(e.ptr));
          if (e.gap) chk("evt_spacing", 64'(cyc - last_xfer_cyc), 64'(2));
          $display("event cmd=%02h ptr=%010h", eve_cmd, eve_ptr);
        end
        last_xfer_cyc = cyc;
        xfer_cnt++;
        wait_cnt = 0;
      end
      prev_pend = eve_stb && !a;
      prev_xfer = xfer;
      prev_cmd  = eve_cmd;
      prev_ptr  = eve_ptr;
    end
  end

  initial begin
    cfg_t c, c2;
    int   n;
    logic [7:0] d;

    // Reset values and auto-start sequence with zero inputs.
    ack_mode = 1;
    repeat (3) step();
    chk("rst_stb", 64'(eve_stb), 64'(0));
    chk("rst_cmd", 64'(eve_cmd), 64'(0));
    chk("rst_ptr", 64'(eve_ptr), 64'(0));
    chk("rst_chr_rdy", 64'(chr_rdy), 64'(1));
    chk("rst_busy", 64'(cfg_busy), 64'(1));
    c = '{base: '0, ph: '0, lw: '0, lh: '0, mode: '0, hp: 1'b0, vp: 1'b0, te: 1'b0};
    push_seq(c, 1'b1);
    rst = 1'b1;
    n = 0;
    while (xfer_cnt < 8 && n < 100) begin step(); n++; end
    chk("auto_seq_count", 64'(xfer_cnt), 64'(8));
    step();
    chk("busy_after_last", 64'(cfg_busy), 64'(0));
    wait_idle("auto_seq");

    // Delayed ack with a known base/mode; inputs changed after the snapshot.
    c = rand_cfg();
    c.base = 39'h12345678;
    c.mode = 2'd2;
    drive_cfg(c);
    ack_mode = 2;
    push_seq(c, 1'b0);
    pulse_start();
    chk("busy_after_start", 64'(cfg_busy), 64'(1));
    step();
    drive_cfg(rand_cfg());
    wait_idle("delayed_seq");

    // Three characters while idle.
    ack_mode = 1;
    for (int i = 0; i < 3; i++) begin
      d = 8'h41 + 8'(i);
      push_chr_exp(d);
      chr_write(d);
    end
    wait_idle("chars_abc");

    // Fill the FIFO with ack held low; the 17th write is dropped.
    ack_mode = 0;
    for (int i = 0; i < 17; i++) begin
      d = 8'($urandom());
      if (i < 16) begin
        chk("chr_rdy_not_full", 64'(chr_rdy), 64'(1));
        push_chr_exp(d);
      end else begin
        chk("chr_rdy_full", 64'(chr_rdy), 64'(0));
      end
      chr_write(d);
    end
    chk("chr_rdy_still_full", 64'(chr_rdy), 64'(0));
    chk("no_xfer_ack_low", 64'(exp_q.size()), 64'(16));
    ack_mode = 1;
    wait_idle("fifo_full");
    chk("chr_rdy_drained", 64'(chr_rdy), 64'(1));

    // Double start during step 3: exactly one extra sequence, then the characters.
    ack_mode = 2;
    c = rand_cfg();
    drive_cfg(c);
    push_seq(c, 1'b0);
    pulse_start();
    wait_for_cmd(CB + 8'd3);
    pulse_start();
    step();
    pulse_start();
    c2 = rand_cfg();
    drive_cfg(c2);
    push_seq(c2, 1'b0);
    for (int i = 0; i < 2; i++) begin
      d = 8'($urandom());
      push_chr_exp(d);
      chr_write(d);
    end
    wait_idle("restart_collapse");

    // Reset while the mode event is waiting for ack.
    c = rand_cfg();
    drive_cfg(c);
    push_seq(c, 1'b0);
    pulse_start();
    wait_for_cmd(CB + 8'd4);
    ack_mode = 0;
    chr_write(8'h55);
    chr_write(8'h66);
    chk("pre_rst_stb", 64'(eve_stb), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_stb", 64'(eve_stb), 64'(0));
    chk("async_rst_ptr", 64'(eve_ptr), 64'(0));
    chk("async_rst_chr_rdy", 64'(chr_rdy), 64'(1));
    exp_q.delete();
    step();
    step();
    push_seq(c, 1'b1);
    ack_mode = 1;
    rst = 1'b1;
    wait_idle("post_rst_seq");

    // Randomized rounds: a sequence, then a burst of characters.
    ack_mode = 3;
    for (int r = 0; r < 3; r++) begin
      c = rand_cfg();
      drive_cfg(c);
      push_seq(c, 1'b0);
      pulse_start();
      wait_idle("rand_seq");
      n = $urandom_range(1, 5);
      for (int i = 0; i < n; i++) begin
        d = 8'($urandom());
        push_chr_exp(d);
        chr_write(d);
      end
      wait_idle("rand_chr");
    end

    chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
